clk_rate_ctrl: RTL and testbench

CLK_RATE_CTRL -- requirements
Module: clk_rate_ctrl

---
 rtl/clk_rate_ctrl.sv | 120 ++++++++++++
 tb/tb_clk_rate_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rate_ctrl.sv
// clk_rate_ctrl: divides clk_50 into a square wave whose half-period is
// BASE_HALF << rate_idx. The rate is stepped with btn_up/btn_dn and
// output is started/stopped with btn_run. All buttons act on rising edges.
module clk_rate_ctrl #(
  parameter int unsigned BASE_HALF = 3_125_000
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_run,
  output logic       clk_out,
  output logic       tick,
  output logic [2:0] rate_idx,
  output logic       running
);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        up_prev_q, up_prev_d;
  logic        dn_prev_q, dn_prev_d;
  logic        run_prev_q, run_prev_d;
  logic [2:0]  rate_q, rate_d;
  logic [25:0] cnt_q, cnt_d;
  logic        clk_out_q, clk_out_d;
  logic        tick_q, tick_d;

  logic        up_ev, dn_ev, run_ev;
  logic        rate_chg;
  logic [25:0] half_w;
  logic [25:0] term_w;

  // Rising-edge detection; prev registers simply follow the inputs.
  always_comb begin
    up_ev      = btn_up  & ~up_prev_q;
    dn_ev      = btn_dn  & ~dn_prev_q;
    run_ev     = btn_run & ~run_prev_q;
    up_prev_d  = btn_up;
    dn_prev_d  = btn_dn;
    run_prev_d = btn_run;
  end

  // Half-period and terminal count, kept at the full 26-bit width.
  always_comb begin
    half_w = 26'(BASE_HALF) << rate_q;
    term_w = half_w - 26'd1;
  end

  // Rate stepping: saturating, and opposing simultaneous events cancel.
  always_comb begin
    rate_d   = rate_q;
    rate_chg = 1'b0;
    if (up_ev && !dn_ev && rate_q != 3'd0) begin
      rate_d   = rate_q - 3'd1;
      rate_chg = 1'b1;
    end else if (dn_ev && !up_ev && rate_q != 3'd4) begin
      rate_d   = rate_q + 3'd1;
      rate_chg = 1'b1;
    end
  end

  // Run/stop FSM plus divider counter; state or rate changes restart the
  // count and take priority over a coincident terminal count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;

    if (run_ev) begin
      state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
    end

    if (run_ev || rate_chg) begin
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      if (cnt_q == term_w) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
        tick_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + 26'd1;
      end
    end
  end

  // State registers with synchronous reset; prevs load 1 so a held button
  // does not produce an event when reset is released.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q    <= ST_STOP;
      up_prev_q  <= 1'b1;
      dn_prev_q  <= 1'b1;
      run_prev_q <= 1'b1;
      rate_q     <= 3'd2;
      cnt_q      <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      up_prev_q  <= up_prev_d;
      dn_prev_q  <= dn_prev_d;
      run_prev_q <= run_prev_d;
      rate_q     <= rate_d;
      cnt_q      <= cnt_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign rate_idx = rate_q;
  assign running  = (state_q == ST_RUN);

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// Directed bench for clk_rate_ctrl with BASE_HALF = 4 (H = 4/8/16/32/64).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_clk_rate_ctrl;

  logic       clk_50;
  logic       rst;
  logic       btn_up;
  logic       btn_dn;
  logic       btn_run;
  logic       clk_out;
  logic       tick;
  logic [2:0] rate_idx;
  logic       running;

  int n_cmp;
  int n_bad;

  clk_rate_ctrl #(.BASE_HALF(4)) dut (
    .clk_50   (clk_50),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_dn   (btn_dn),
    .btn_run  (btn_run),
    .clk_out  (clk_out),
    .tick     (tick),
    .rate_idx (rate_idx),
    .running  (running)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  // Waits for the next clk_out change and checks its latency, that tick
  // rises with it, and that tick stayed low while waiting.
  task automatic wait_toggle(input string tag, input int exp_n);
    logic lvl;
    int   n;
    int   ticks;
    lvl   = clk_out;
    n     = 0;
    ticks = 0;
    while (n <= 200) begin
      @(posedge clk_50);
      #1;
      n++;
      if (clk_out !== lvl) break;
      if (tick === 1'b1) ticks++;
    end
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_tick"}, {31'd0, tick}, 1);
    chk({tag, "_quiet"}, ticks, 0);
  endtask

  // Aligns to the next toggle without checking its latency.
  task automatic sync_toggle(input string tag);
    logic lvl;
    int   n;
    lvl = clk_out;
    n   = 0;
    while (n <= 200) begin
      @(posedge clk_50);
      #1;
      n++;
      if (clk_out !== lvl) break;
    end
    chk({tag, "_sync"}, {31'd0, (n <= 200)}, 1);
  endtask

  task automatic pulse_up();
    btn_up = 1'b1; step(1); btn_up = 1'b0; step(1);
  endtask

  task automatic pulse_dn();
    btn_dn = 1'b1; step(1); btn_dn = 1'b0; step(1);
  endtask

  initial begin
    logic lvl;
    int   bad_tick;
    int   bad_lvl;
    int   bad_run;

    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    btn_up  = 1'b0;
    btn_dn  = 1'b0;
    btn_run = 1'b0;

    // Reset values
    step(2);
    rst = 1'b0;
    chk("rst_clk_out", {31'd0, clk_out}, 0);
    chk("rst_tick", {31'd0, tick}, 0);
    chk("rst_rate", {29'd0, rate_idx}, 2);
    chk("rst_running", {31'd0, running}, 0);
    step(3);
    chk("stop_clk_out", {31'd0, clk_out}, 0);

    // Start: toggles every 16 cycles at rate 2
    btn_run = 1'b1;
    step(1);
    btn_run = 1'b0;
    chk("run_on", {31'd0, running}, 1);
    wait_toggle("first", 16);
    chk("first_level", {31'd0, clk_out}, 1);
    wait_toggle("second", 16);
    wait_toggle("third", 16);

    // btn_up held 10 cycles: one event, count restarts at H = 8
    step(5);
    lvl    = clk_out;
    btn_up = 1'b1;
    step(1);
    chk("up_rate", {29'd0, rate_idx}, 1);
    chk("up_level_kept", {31'd0, clk_out}, {31'd0, lvl});
    wait_toggle("up_held", 8);
    step(1);
    btn_up = 1'b0;
    chk("up_rate_held", {29'd0, rate_idx}, 1);
    wait_toggle("r1", 7);

    // Saturation at both ends
    repeat (5) pulse_up();
    chk("sat_low", {29'd0, rate_idx}, 0);
    repeat (6) pulse_dn();
    chk("sat_high", {29'd0, rate_idx}, 4);
    sync_toggle("r4");
    wait_toggle("r4", 64);

    // Ignored request at rate 4 leaves the count running
    step(10);
    btn_dn = 1'b1;
    step(1);
    btn_dn = 1'b0;
    step(1);
    chk("sat_dn_rate", {29'd0, rate_idx}, 4);
    wait_toggle("sat_dn", 52);

    // Back to rate 2
    pulse_up();
    pulse_up();
    chk("back_r2", {29'd0, rate_idx}, 2);
    sync_toggle("r2");
    wait_toggle("r2", 16);

    // Simultaneous up/down: ignored, schedule intact
    step(5);
    btn_up = 1'b1;
    btn_dn = 1'b1;
    step(1);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    step(1);
    chk("both_rate", {29'd0, rate_idx}, 2);
    wait_toggle("both", 9);

    // Stop at cnt = 7: level held, no tick for 100 cycles
    step(7);
    lvl     = clk_out;
    btn_run = 1'b1;
    step(1);
    btn_run = 1'b0;
    chk("stop_running", {31'd0, running}, 0);
    chk("stop_level", {31'd0, clk_out}, {31'd0, lvl});
    chk("stop_tick", {31'd0, tick}, 0);
    bad_tick = 0;
    bad_lvl  = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (tick !== 1'b0) bad_tick++;
      if (clk_out !== lvl) bad_lvl++;
    end
    chk("stop_hold_tick", bad_tick, 0);
    chk("stop_hold_level", bad_lvl, 0);
    btn_run = 1'b1;
    step(1);
    btn_run = 1'b0;
    chk("restart_running", {31'd0, running}, 1);
    wait_toggle("restart", 16);

    // Reset mid-run at cnt = 10 with btn_run held through and after reset
    step(10);
    btn_run = 1'b1;
    rst     = 1'b1;
    step(1);
    chk("midrst_running", {31'd0, running}, 0);
    chk("midrst_rate", {29'd0, rate_idx}, 2);
    chk("midrst_clk_out", {31'd0, clk_out}, 0);
    chk("midrst_tick", {31'd0, tick}, 0);
    step(2);
    rst     = 1'b0;
    bad_run = 0;
    bad_lvl = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (running !== 1'b0) bad_run++;
      if (clk_out !== 1'b0) bad_lvl++;
    end
    chk("held_run_no_event", bad_run, 0);
    chk("held_run_level", bad_lvl, 0);
    btn_run = 1'b0;
    step(3);
    chk("after_release", {31'd0, running}, 0);
    btn_run = 1'b1;
    step(1);
    btn_run = 1'b0;
    chk("fresh_event", {31'd0, running}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
